// File: rtl/cbfp_block_norm.sv
// Block-floating-point normaliser: buffers BLK_CYC-beat blocks in a ping-pong RAM, finds the common shift, replays shifted/rounded/narrowed.
// Latency: first output beat one cycle after a block's last input beat; no backpressure, a full replay always finishes before the next bank closes.
module cbfp_block_norm #(
    parameter int N         = 16,
    parameter int IN_W      = 16,
    parameter int OUT_W     = 13,
    parameter int BLK_CYC   = 4,
    parameter int IDX_W     = 5,
    parameter int MAX_SHIFT = 12,
    localparam int SW       = $clog2(MAX_SHIFT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic                         norm_en,
    input  logic [N-1:0][IN_W-1:0]       din_i,
    input  logic [N-1:0][IN_W-1:0]       din_q,
    input  logic [N-1:0][IDX_W-1:0]      index_in,
    output logic                         valid_out,
    output logic [N-1:0][OUT_W-1:0]      dout_i,
    output logic [N-1:0][OUT_W-1:0]      dout_q,
    output logic [N-1:0][IDX_W-1:0]      index_out,
    output logic [SW-1:0]                shift_out,
    output logic                         sob_out,
    output logic                         eob_out
);
    localparam int D  = IN_W - OUT_W;
    localparam int RW = $clog2(IN_W);
    localparam int CW = $clog2(BLK_CYC);
    localparam int XW = IDX_W + SW;
    localparam logic [SW-1:0]         MAXS = SW'(MAX_SHIFT);
    localparam logic [CW-1:0]         LAST = CW'(BLK_CYC - 1);
    localparam logic signed [IN_W:0]  RND  = (IN_W+1)'(1 << (D - 1));
    localparam logic signed [IN_W:0]  OMAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0]  OMIN = (IN_W+1)'(-(1 << (OUT_W - 1)));
    localparam logic [XW-1:0]         IMAX = XW'((1 << IDX_W) - 1);

    function automatic logic [RW-1:0] rsc(input logic [IN_W-1:0] x);
        logic [RW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int b = IN_W - 2; b >= 0; b--) begin
            run = run & (x[b] == x[IN_W-1]);
            if (run) n = n + RW'(1);
        end
        return n;
    endfunction

    // Shift is exact (s never exceeds the redundant sign count); the extra bit absorbs the rounding carry.
    function automatic logic [OUT_W-1:0] norm(input logic [IN_W-1:0] x, input logic [SW-1:0] s);
        logic signed [IN_W-1:0] y;
        logic signed [IN_W:0]   t;
        y = $signed(x) <<< s;
        t = $signed({y[IN_W-1], y}) + RND;
        t = t >>> D;
        if (t > OMAX) return OMAX[OUT_W-1:0];
        if (t < OMIN) return OMIN[OUT_W-1:0];
        return t[OUT_W-1:0];
    endfunction

    logic [N-1:0][IN_W-1:0]  mi_q [2][BLK_CYC];
    logic [N-1:0][IN_W-1:0]  mq_q [2][BLK_CYC];
    logic [N-1:0][IDX_W-1:0] mx_q [2][BLK_CYC];

    logic [CW-1:0] wc_q, rc_q;
    logic          wb_q, rb_q, en_q, rd_act_q;
    logic [SW-1:0] m_q, rs_q;
    logic [RW-1:0] bmin;
    logic [SW-1:0] mbase, m_d, s_d;
    logic          first, en_d, close;

    always_comb begin
        bmin = RW'(IN_W - 1);
        for (int l = 0; l < N; l++) begin
            if (rsc(din_i[l]) < bmin) bmin = rsc(din_i[l]);
            if (rsc(din_q[l]) < bmin) bmin = rsc(din_q[l]);
        end
        first = (wc_q == '0);
        mbase = first ? MAXS : m_q;
        m_d   = (int'(bmin) < int'(mbase)) ? SW'(bmin) : mbase;
        en_d  = first ? norm_en : en_q;
        s_d   = en_d ? m_d : '0;
        close = valid_in && (wc_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            mi_q[wb_q][wc_q] <= din_i;
            mq_q[wb_q][wc_q] <= din_q;
            mx_q[wb_q][wc_q] <= index_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_q <= '0;
            wb_q <= 1'b0;
            en_q <= 1'b0;
            m_q  <= MAXS;
        end else if (valid_in) begin
            en_q <= en_d;
            if (close) begin
                wc_q <= '0;
                wb_q <= ~wb_q;
                m_q  <= MAXS;
            end else begin
                wc_q <= wc_q + CW'(1);
                m_q  <= m_d;
            end
        end
    end

    // A bank closing on the edge that emits the previous block's last beat chains straight into a new replay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_act_q <= 1'b0;
            rc_q     <= '0;
            rb_q     <= 1'b0;
            rs_q     <= '0;
        end else if (close) begin
            rd_act_q <= 1'b1;
            rc_q     <= '0;
            rb_q     <= wb_q;
            rs_q     <= s_d;
        end else if (rd_act_q) begin
            if (rc_q == LAST) rd_act_q <= 1'b0;
            else              rc_q     <= rc_q + CW'(1);
        end
    end

    logic [N-1:0][OUT_W-1:0] di_d, dq_d;
    logic [N-1:0][IDX_W-1:0] ix_d;
    logic [XW-1:0]           isum;

    always_comb begin
        di_d = '0;
        dq_d = '0;
        ix_d = '0;
        isum = '0;
        for (int l = 0; l < N; l++) begin
            di_d[l] = norm(mi_q[rb_q][rc_q][l], rs_q);
            dq_d[l] = norm(mq_q[rb_q][rc_q][l], rs_q);
            isum    = XW'(mx_q[rb_q][rc_q][l]) + XW'(rs_q);
            ix_d[l] = (isum > IMAX) ? IMAX[IDX_W-1:0] : isum[IDX_W-1:0];
        end
    end

    logic                    vld_q, sob_q, eob_q;
    logic [N-1:0][OUT_W-1:0] di_q, dq_q;
    logic [N-1:0][IDX_W-1:0] ix_q;
    logic [SW-1:0]           sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            sob_q <= 1'b0;
            eob_q <= 1'b0;
            di_q  <= '0;
            dq_q  <= '0;
            ix_q  <= '0;
            sh_q  <= '0;
        end else begin
            vld_q <= rd_act_q;
            sob_q <= rd_act_q && (rc_q == '0);
            eob_q <= rd_act_q && (rc_q == LAST);
            if (rd_act_q) begin
                di_q <= di_d;
                dq_q <= dq_d;
                ix_q <= ix_d;
                sh_q <= rs_q;
            end
        end
    end

    assign valid_out = vld_q;
    assign sob_out   = sob_q;
    assign eob_out   = eob_q;
    assign dout_i    = di_q;
    assign dout_q    = dq_q;
    assign index_out = ix_q;
    assign shift_out = sh_q;
endmodule

// File: tb/tb_cbfp_block_norm.sv
// Bench for cbfp_block_norm: arithmetic reference model feeds a scoreboard queue, negedge monitor checks every output beat.
module tb_cbfp_block_norm;
    localparam int N = 16, IN_W = 16, OUT_W = 13, BLK_CYC = 4, IDX_W = 5, MAX_SHIFT = 12;
    localparam int SW = $clog2(MAX_SHIFT + 1);
    localparam int D  = IN_W - OUT_W;

    typedef logic [N-1:0][IN_W-1:0]  lane_t;
    typedef logic [N-1:0][IDX_W-1:0] ixv_t;
    typedef logic [N-1:0][OUT_W-1:0] olane_t;
    typedef struct {
        olane_t        di, dq;
        ixv_t          ix;
        logic [SW-1:0] sh;
        logic          sob, eob;
        int            cyc;
    } exp_t;

    logic clk, rst, valid_in, norm_en;
    lane_t din_i, din_q;
    ixv_t index_in, index_out;
    logic valid_out, sob_out, eob_out;
    olane_t dout_i, dout_q;
    logic [SW-1:0] shift_out;

    cbfp_block_norm #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .BLK_CYC(BLK_CYC),
                      .IDX_W(IDX_W), .MAX_SHIFT(MAX_SHIFT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .norm_en(norm_en),
        .din_i(din_i), .din_q(din_q), .index_in(index_in),
        .valid_out(valid_out), .dout_i(dout_i), .dout_q(dout_q),
        .index_out(index_out), .shift_out(shift_out),
        .sob_out(sob_out), .eob_out(eob_out));

    exp_t   exp_q[$];
    exp_t   me;
    int     n_chk = 0, n_fail = 0, cyc = 0, bcnt = 0;
    bit     blk_en;
    longint blk_re[BLK_CYC][N], blk_im[BLK_CYC][N];
    int     blk_ix[BLK_CYC][N];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input string got, input string want);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endtask

    // Largest k such that x*2^k still fits in IN_W signed bits.
    function automatic int rsc_m(input longint x);
        longint hi = (longint'(1) <<< (IN_W - 1)) - 1;
        longint lo = -hi - 1;
        int k = 0;
        while (k < IN_W - 1 && (x <<< (k + 1)) <= hi && (x <<< (k + 1)) >= lo) k++;
        return k;
    endfunction

    function automatic longint qnt(input longint x, input int s);
        longint omax = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint t = ((x <<< s) + (longint'(1) <<< (D - 1))) >>> D;
        if (t > omax) t = omax;
        if (t < -omax - 1) t = -omax - 1;
        return t;
    endfunction

    function automatic lane_t fill(input longint v);
        lane_t r;
        for (int l = 0; l < N; l++) r[l] = IN_W'(v);
        return r;
    endfunction

    function automatic ixv_t fillx(input int v);
        ixv_t r;
        for (int l = 0; l < N; l++) r[l] = IDX_W'(v);
        return r;
    endfunction

    function automatic lane_t rnd_lanes(input int k);
        lane_t r;
        for (int l = 0; l < N; l++) begin
            int kk = $urandom_range(1, k);
            r[l] = IN_W'(longint'($urandom_range(0, (1 << kk) - 1)) - (longint'(1) <<< (kk - 1)));
        end
        return r;
    endfunction

    function automatic ixv_t rnd_ix();
        ixv_t r;
        for (int l = 0; l < N; l++) r[l] = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
        return r;
    endfunction

    task automatic finish_block(input int t);
        int m = MAX_SHIFT;
        int s;
        exp_t e;
        for (int j = 0; j < BLK_CYC; j++)
            for (int l = 0; l < N; l++) begin
                if (rsc_m(blk_re[j][l]) < m) m = rsc_m(blk_re[j][l]);
                if (rsc_m(blk_im[j][l]) < m) m = rsc_m(blk_im[j][l]);
            end
        s = blk_en ? m : 0;
        for (int j = 0; j < BLK_CYC; j++) begin
            for (int l = 0; l < N; l++) begin
                int ix = blk_ix[j][l] + s;
                e.di[l] = OUT_W'(qnt(blk_re[j][l], s));
                e.dq[l] = OUT_W'(qnt(blk_im[j][l], s));
                e.ix[l] = IDX_W'((ix > (1 << IDX_W) - 1) ? (1 << IDX_W) - 1 : ix);
            end
            e.sh  = SW'(s);
            e.sob = (j == 0);
            e.eob = (j == BLK_CYC - 1);
            e.cyc = t + 1 + j;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            valid_in = 1'b0;
            norm_en  = 1'($urandom);
            din_i    = rnd_lanes(IN_W);
            din_q    = rnd_lanes(IN_W);
            index_in = rnd_ix();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input bit en, input lane_t vi, input lane_t vq, input ixv_t vx);
        valid_in = 1'b1;
        norm_en  = en;
        din_i    = vi;
        din_q    = vq;
        index_in = vx;
        @(posedge clk);
        #1;
        if (bcnt == 0) blk_en = en;
        for (int l = 0; l < N; l++) begin
            blk_re[bcnt][l] = longint'($signed(vi[l]));
            blk_im[bcnt][l] = longint'($signed(vq[l]));
            blk_ix[bcnt][l] = int'(vx[l]);
        end
        bcnt++;
        if (bcnt == BLK_CYC) begin
            finish_block(cyc);
            bcnt = 0;
        end
        valid_in = 1'b0;
    endtask

    task automatic rnd_block(input int gap_pct);
        int k = $urandom_range(1, IN_W);
        for (int j = 0; j < BLK_CYC; j++) begin
            if (int'($urandom_range(0, 99)) < gap_pct) idle($urandom_range(1, 3));
            beat(($urandom % 4) != 0, rnd_lanes(k), rnd_lanes(k), rnd_ix());
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, valid_out === 1'b0 && sob_out === 1'b0 && eob_out === 1'b0 &&
                  dout_i === '0 && dout_q === '0 && index_out === '0 && shift_out === '0,
            $sformatf("vld=%b sob=%b eob=%b i=%h q=%h ix=%h sh=%0d", valid_out, sob_out, eob_out,
                      dout_i, dout_q, index_out, shift_out), "all zero");
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        chk("drain", exp_q.size() == 0, $sformatf("%0d beats pending", exp_q.size()), "0 pending");
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) begin
                chk("no_spurious_beat", exp_q.size() != 0, $sformatf("valid_out at cycle %0d", cyc), "no output");
                if (exp_q.size() != 0) begin
                    me = exp_q.pop_front();
                    chk("beat", cyc == me.cyc && dout_i === me.di && dout_q === me.dq &&
                                index_out === me.ix && shift_out === me.sh &&
                                sob_out === me.sob && eob_out === me.eob,
                        $sformatf("@%0d i=%h q=%h ix=%h sh=%0d sob=%b eob=%b", cyc, dout_i, dout_q,
                                  index_out, shift_out, sob_out, eob_out),
                        $sformatf("@%0d i=%h q=%h ix=%h sh=%0d sob=%b eob=%b", me.cyc, me.di, me.dq,
                                  me.ix, me.sh, me.sob, me.eob));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                me = exp_q.pop_front();
                chk("beat_present", 1'b0, $sformatf("no valid_out at cycle %0d", cyc),
                    $sformatf("beat due at cycle %0d", me.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        lane_t v;
        rst      = 1'b1;
        valid_in = 1'b0;
        norm_en  = 1'b0;
        din_i    = '0;
        din_q    = '0;
        index_in = '0;
        @(posedge clk);
        #1;
        chk_zero("reset_state");
        idle(2);
        rst = 1'b0;
        idle(1);

        // Directed blocks: constant, zero, index saturation, bypass, output saturation.
        repeat (BLK_CYC) beat(1'b1, fill(256), fill(-256), fillx(3));
        idle(2);
        repeat (BLK_CYC) beat(1'b1, fill(0), fill(0), fillx(3));
        repeat (BLK_CYC) beat(1'b1, fill(0), fill(0), fillx(25));
        for (int j = 0; j < BLK_CYC; j++) beat(j != 0, fill(256), fill(-256), fillx(3));
        v = fill(0);
        v[0] = 16'h7fff;
        beat(1'b1, v, fill(0), fillx(0));
        repeat (BLK_CYC - 1) beat(1'b1, fill(0), fill(0), fillx(0));
        v[0] = 16'h8000;
        beat(1'b1, fill(0), v, fillx(7));
        repeat (BLK_CYC - 1) beat(1'b1, fill(0), fill(0), fillx(7));
        drain();

        repeat (10) rnd_block(0);
        repeat (10) rnd_block(30);
        drain();

        // Reset during a partial block, then during a replay.
        beat(1'b1, rnd_lanes(8), rnd_lanes(8), rnd_ix());
        beat(1'b1, rnd_lanes(8), rnd_lanes(8), rnd_ix());
        rst = 1'b1;
        #1;
        chk_zero("reset_partial");
        exp_q.delete();
        bcnt = 0;
        idle(2);
        rst = 1'b0;
        idle(1);
        rnd_block(0);
        idle(2);
        rst = 1'b1;
        #1;
        chk_zero("reset_replay");
        exp_q.delete();
        bcnt = 0;
        idle(2);
        rst = 1'b0;
        idle(8);
        rnd_block(0);
        rnd_block(0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cbfp_block_norm.md
# cbfp_block_norm

Parametrised convergent-block-floating-point normaliser for the FFT datapath. It accepts N-lane complex beats from a butterfly stage and groups them into blocks of BLK_CYC beats. It finds the largest common left shift that keeps every sample of a block in range, then replays the block shifted, rounded and narrowed, with per-sample exponent indices accumulated. It generalises the fixed CBFP stages in width, lane count, block length, shift limit and run-time bypass. A ping-pong buffer lets it sustain back-to-back input.

## Interface
- N, 16: lanes per beat
- IN_W, 16: input sample width (signed)
- OUT_W, 13: output sample width; IN_W-OUT_W (D) must be ≥1
- BLK_CYC, 4: beats per block (≥2)
- IDX_W, 5: exponent index width
- MAX_SHIFT, 12: largest block shift allowed, ≤ IN_W-1

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  beat valid; no backpressure
- norm_en  in  1  0 forces shift 0; sampled on the first beat of each block
- din_i / din_q  in  [IN_W-1:0] x N  signed re/im
- index_in  in  [IDX_W-1:0] x N  per-lane incoming exponent, aligned with din
- valid_out  out  1  output beat valid
- dout_i / dout_q  out  [OUT_W-1:0] x N  signed normalised re/im
- index_out  out  [IDX_W-1:0] x N  accumulated exponent
- shift_out  out  [$clog2(MAX_SHIFT+1)-1:0]  block shift s, constant for the block
- sob_out / eob_out  out  1  first / last beat of the block (qualified by valid_out)

## Operation
- Write side: the beat counter wc counts 0..BLK_CYC-1 on valid_in. Each beat is written to bank wb at address wc. On wc==BLK_CYC-1 the bank is closed, wb toggles and wc wraps to 0.
- Per-sample redundant-sign count r(x): the number of bits below the MSB equal to the MSB. Examples: r(0)=IN_W-1; r(256)=6 and r(-256)=7 at IN_W=16.
- Running minimum m: m = min over all re and im samples of the block. It is reset to MAX_SHIFT at block start.
- Block shift: s = norm_en_latched ? min(m, MAX_SHIFT) : 0. s is registered when the bank closes.
- Read side: once a bank closes, it is replayed over BLK_CYC consecutive cycles with no gaps, in address order.
- Arithmetic per component:
  - y = x <<< s, which is exact because s ≤ r.
  - out = sat_OUT_W((y + 2^(D-1)) >>> D): round half up, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- index_out = min(index_in + s, 2^IDX_W-1).
- Both banks can never be pending at once: a read takes exactly BLK_CYC cycles, and a write takes ≥ BLK_CYC cycles. No overflow or stall logic is needed.
- Gaps in valid_in mid-block are allowed. The block simply completes later.
- norm_en changes mid-block are ignored until the next first beat.

## Timing
- Reset: all of the following clear to 0:
  - valid_out, sob_out, eob_out
  - dout_i, dout_q, index_out, shift_out
  - wc, wb, the read counter and the read-active flag
- m resets to MAX_SHIFT. A partial block in flight is discarded.
- Buffer contents need no reset.
- Let the last beat of a block be captured at edge t.
  - Output beat j is registered at edge t+1+j, for j = 0..BLK_CYC-1.
  - sob_out is high with beat 0; eob_out is high with beat BLK_CYC-1.
- The first-beat latency of a block is BLK_CYC cycles when input is continuous.
- Back-to-back blocks produce continuous valid_out with no bubble.
- The final beat of block k+1 may close at the same edge that block k's last output is registered. Block k+1 replay then starts on the next edge.
- The read of bank b and the write of bank !b on the same edge are independent.
- rst asserted mid-replay: valid_out drops asynchronously. The remaining beats are never emitted.

## Test plan
- Constant block, BLK_CYC=4, all re=256, im=-256, index_in=3, norm_en=1 → s=6. Every beat has dout_i=2048, dout_q=-2048, index_out=9, shift_out=6. sob is on beat 0 and eob on beat 3.
- All-zero block → s=12, dout=0, index_out=index_in+12. A second block with index_in=25 → index_out saturates at 31.
- Same stimulus with norm_en=0 → s=0, dout_i=(256+4)>>>3=32, dout_q=-32, index_out=3.
- Saturation: single sample re=32767 with all others 0 → s=0, dout_i=4095 (rounding overflow saturates). A sample of -32768 → -4096.
- 10 back-to-back blocks of random data, then random valid_in gaps → valid_out continuous per block, ordering preserved. Output matches the golden model bit-exactly, with latency t+1 after each block's last beat.
- rst pulsed after 2 beats of a block and again during replay → all outputs 0 immediately, and nothing is emitted for the aborted blocks. The next full block is output correctly.
